multicycle_controller: RTL

- Sequences a shared-ALU, multi-cycle RV32I-subset datapath. Handles addi, bne, lw and sw.
- Replaces the single-cycle decoder: the ALU, register file and unified memory port are reused across cycles, under FSM control.
- Sits between the instruction register / EQ flag and the datapath enables and muxes.
- Uses a memory-port handshake so memory latency is variable.

---
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-ALU multi-cycle
// RV32I subset datapath (addi, bne, lw, sw) over one handshaked memory port.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   instr, EQ         instruction register contents, ALU zero flag
//   mem_ready         memory finished the current access this cycle
//   mem_req, mem_we   memory request / write qualifier
//   IRWrite, PCWrite  IR (and OldPC) load, PC update enable
//   PCsrc             0 = PC+4, 1 = branch target
//   RegWrite          register-file write enable
//   ALUsrc, ImmSrc    ALU B select, immediate format (00 I, 01 S, 10 B)
//   ALUctrl           000 add, 001 sub
//   ResultSrc         0 ALU result, 1 memory read data
//   halted            controller sits in TRAP
//   cycle_count,
//   instr_count       performance counters, tied to 0 unless the
//                     macro MULTICYCLE_PERF_CNT_EN is defined
module multicycle_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [1:0]            ImmSrc,
    output logic [2:0]            ALUctrl,
    output logic                  ResultSrc,
    output logic                  halted,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instr_count
);

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        EXEC_I,
        ALU_WB,
        EXEC_B,
        MEM_ADDR,
        MEM_ACC,
        MEM_WB,
        TRAP
    } state_t;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_addi, is_bne, is_lw, is_sw, is_store;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    // Only lw/sw reach the memory states, so the opcode alone picks the side.
    assign is_store = (opcode == 7'b0100011);

    logic unused_instr;
    assign unused_instr = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ImmSrc    = 2'b00;
        ALUctrl   = 3'b000;
        ResultSrc = 1'b0;
        halted    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_addi) begin
                    state_d = EXEC_I;
                end else if (is_bne) begin
                    state_d = EXEC_B;
                end else if (is_lw || is_sw) begin
                    state_d = MEM_ADDR;
                end else begin
                    state_d = TRAP;
                end
            end
            EXEC_I: begin
                ALUsrc  = 1'b1;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            EXEC_B: begin
                // Compare via subtract; target adder works from OldPC.
                ALUctrl = 3'b001;
                ImmSrc  = 2'b10;
                PCsrc   = ~EQ;
                PCWrite = ~EQ;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                ALUsrc  = 1'b1;
                ImmSrc  = is_store ? 2'b01 : 2'b00;
                state_d = MEM_ACC;
            end
            MEM_ACC: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    state_d = is_store ? FETCH : MEM_WB;
                end
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                halted  = 1'b1;
                state_d = TRAP;
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ins_q, ins_d;
    logic        retire;

    // MEM_ACC only returns to FETCH for a completed store.
    assign retire = (state_d == FETCH) &&
                    ((state_q == ALU_WB) || (state_q == EXEC_B) ||
                     (state_q == MEM_ACC) || (state_q == MEM_WB));

    assign cyc_d = (state_q != TRAP) ? cyc_q + 32'd1 : cyc_q;
    assign ins_d = retire ? ins_q + 32'd1 : ins_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 32'd0;
            ins_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule
